// File: rtl/run_sequencer_pkg.sv
// Shared state encoding and index-width helper for the run sequencer and its trace buffer.
package run_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_sequencer_trace_buffer.sv
// Circular (pc, inst) trace with saturating fill count; reads are relative to the oldest entry.
module trace_buffer
   import run_sequencer_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    we,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [idx_w(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic [idx_w(DEPTH):0]   count
);
   localparam int AW = idx_w(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [AW-1:0]     rd_idx;

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (clr) begin
         ptr_d   = '0;
         count_d = '0;
      end else if (we) begin
         ptr_d = ptr_q + 1'b1;
         if (count_q != FULL) count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we && !clr) mem_q[ptr_q] <= wr_data;
   end

   // count == DEPTH truncates to 0 in AW bits, which is exactly the wrap we want
   assign rd_idx  = ptr_q - count_q[AW-1:0] + rd_addr;
   assign rd_data = ({1'b0, rd_addr} < count_q) ? mem_q[rd_idx] : '0;
   assign count   = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: sequences NUM_PROGS programs through the core start/done handshake,
// with per-program watchdog, saturating RUN-cycle counter and a (pc, inst) trace.
//   state  | meaning
//   IDLE   | after reset, waiting for go
//   LAUNCH | one cycle, core_start raised, core_done ignored, watchdog cleared
//   RUN    | program executing; count cycles, trace, watch for done/timeout
//   GAP    | core_start low, waiting for core_done to drop before next program
//   FINISH | sequence over; run_done pulsed on entry, go starts a new sequence
module run_sequencer
   import run_sequencer_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int INST_W      = 9,
   parameter int NUM_PROGS   = 3,
   parameter int TIMEOUT_W   = 16,
   parameter int CYC_W       = 32,
   parameter int TRACE_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic [TIMEOUT_W-1:0]          timeout_limit,
   input  logic                          core_done,
   input  logic [PC_W-1:0]               core_pc,
   input  logic [INST_W-1:0]             core_inst,
   output logic                          core_start,
   output logic [idx_w(NUM_PROGS)-1:0]   prog_sel,
   output logic                          busy,
   output logic                          run_done,
   output logic                          timed_out,
   output logic [CYC_W-1:0]              cycle_count,
   input  logic [idx_w(TRACE_DEPTH)-1:0] trace_rd_addr,
   output logic [PC_W-1:0]               trace_rd_pc,
   output logic [INST_W-1:0]             trace_rd_inst,
   output logic [idx_w(TRACE_DEPTH):0]   trace_count
);
   localparam int SEL_W  = idx_w(NUM_PROGS);
   localparam int DATA_W = PC_W + INST_W;
   localparam logic [SEL_W-1:0] LAST_PROG = SEL_W'(NUM_PROGS - 1);

   state_e               state_q, state_d;
   logic                 core_start_q, core_start_d;
   logic                 busy_q, busy_d;
   logic                 run_done_q, run_done_d;
   logic                 timed_out_q, timed_out_d;
   logic [SEL_W-1:0]     prog_sel_q, prog_sel_d;
   logic [CYC_W-1:0]     cycle_count_q, cycle_count_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic                 trace_we, trace_clr;
   logic [DATA_W-1:0]    trace_rd_data;

   always_comb begin
      state_d       = state_q;
      prog_sel_d    = prog_sel_q;
      timed_out_d   = timed_out_q;
      cycle_count_d = cycle_count_q;
      wd_d          = wd_q;
      limit_d       = limit_q;
      trace_we      = 1'b0;
      trace_clr     = 1'b0;
      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (go) begin
               state_d       = ST_LAUNCH;
               prog_sel_d    = '0;
               timed_out_d   = 1'b0;
               cycle_count_d = '0;
               limit_d       = timeout_limit;
               wd_d          = '0;
               trace_clr     = 1'b1;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_RUN;
            wd_d    = '0;
         end
         ST_RUN: begin
            wd_d     = wd_q + 1'b1;
            trace_we = 1'b1;
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
            // done takes priority over a watchdog expiry in the same cycle
            if (core_done) begin
               state_d = (prog_sel_q == LAST_PROG) ? ST_FINISH : ST_GAP;
            end else if (limit_q != '0 && wd_d == limit_q) begin
               timed_out_d = 1'b1;
               state_d     = ST_FINISH;
            end
         end
         ST_GAP: begin
            if (!core_done) begin
               state_d    = ST_LAUNCH;
               prog_sel_d = prog_sel_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      core_start_d = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
      busy_d       = core_start_d || (state_d == ST_GAP);
      run_done_d   = (state_d == ST_FINISH) && (state_q != ST_FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         core_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         run_done_q    <= 1'b0;
         timed_out_q   <= 1'b0;
         prog_sel_q    <= '0;
         cycle_count_q <= '0;
         wd_q          <= '0;
         limit_q       <= '0;
      end else begin
         state_q       <= state_d;
         core_start_q  <= core_start_d;
         busy_q        <= busy_d;
         run_done_q    <= run_done_d;
         timed_out_q   <= timed_out_d;
         prog_sel_q    <= prog_sel_d;
         cycle_count_q <= cycle_count_d;
         wd_q          <= wd_d;
         limit_q       <= limit_d;
      end
   end

   trace_buffer #(
      .DEPTH  (TRACE_DEPTH),
      .DATA_W (DATA_W)
   ) u_trace (
      .clk     (clk),
      .rst     (rst),
      .clr     (trace_clr),
      .we      (trace_we),
      .wr_data ({core_pc, core_inst}),
      .rd_addr (trace_rd_addr),
      .rd_data (trace_rd_data),
      .count   (trace_count)
   );

   assign core_start  = core_start_q;
   assign busy        = busy_q;
   assign run_done    = run_done_q;
   assign timed_out   = timed_out_q;
   assign prog_sel    = prog_sel_q;
   assign cycle_count = cycle_count_q;
   assign {trace_rd_pc, trace_rd_inst} = trace_rd_data;

endmodule
